rr_arbiter8: RTL

Eight-requester round-robin arbiter that shares a single downstream resource (bus, encoder datapath, or shared port) between up to eight clients. It produces a registered one-hot grant, the same grant in binary-encoded form, and a watchdog preemption so that no client can hold the resource indefinitely. It sits between the request lines of the clients and the select input of the shared resource.

---
 rtl/rr_arbiter8_if.sv | 25 ++
 rtl/rr_arbiter8.sv | 124 ++++++++++++
 2 files changed

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between up to eight clients and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) returns the grant.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-client round-robin arbiter with registered one-hot/binary grant and a
// hold-time watchdog that hands the resource to a waiting client after MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] last_q, last_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       preempt_q, preempt_d;

    logic [7:0] owner_mask;
    logic [7:0] cand;
    logic       owner_req;
    logic       timeout;
    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] probe;

    // While busy the current owner is excluded, so release and timeout share one search.
    always_comb begin
        owner_mask = 8'b1 << last_q;
        cand       = (state_q == BUSY) ? (bus.req & ~owner_mask) : bus.req;
        owner_req  = |(bus.req & owner_mask);
        timeout    = owner_req && (hold_cnt_q == MAX_HOLD_C) && (|cand);
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            probe = last_q + 3'(k);
            if (!win_found && cand[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = BUSY;
                    last_d      = win_idx;
                    hold_cnt_d  = 8'd1;
                    gnt_d       = 8'b1 << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (!owner_req || timeout) begin
                    if (win_found) begin
                        last_d      = win_idx;
                        hold_cnt_d  = 8'd1;
                        gnt_d       = 8'b1 << win_idx;
                        gnt_idx_d   = win_idx;
                        gnt_valid_d = 1'b1;
                        // Owner still requesting here means this handover is a preemption.
                        preempt_d   = owner_req;
                    end else begin
                        state_d     = IDLE;
                        hold_cnt_d  = '0;
                        gnt_d       = '0;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (hold_cnt_q < MAX_HOLD_C) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= '1;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.preempt   = preempt_q;

endmodule
